// File: rtl/uart_prog_loader_pkg.sv
// Shared types and constants for the UART boot program loader.
package uart_prog_loader_pkg;

  typedef enum logic [1:0] {S_LOAD, S_WRITE, S_DONE} loader_state_e;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} uart_rx_state_e;

  localparam logic [31:0] DEFAULT_END_WORD = 32'h0000_0FFF;

endpackage

// File: rtl/uart_prog_loader_rx_deser.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, one-cycle byte/framing pulses.
module uart_rx_deser
  import uart_prog_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_TC  = CW'(CLKS_PER_BIT - 1);

  uart_rx_state_e state;
  logic           rx_meta, rx_sync, rx_prev;
  logic [CW-1:0]  cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shreg;

  assign byte_o = shreg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta      <= 1'b1;
      rx_sync      <= 1'b1;
      rx_prev      <= 1'b1;
      state        <= RX_IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      byte_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      rx_meta      <= rx_i;
      rx_sync      <= rx_meta;
      rx_prev      <= rx_sync;
      byte_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
      case (state)
        // only a high-to-low transition arms, so a line stuck low never re-triggers
        RX_IDLE: if (rx_prev && !rx_sync) begin
          state <= RX_START;
          cnt   <= HALF_TC;
        end
        RX_START: if (cnt == '0) begin
          if (rx_sync) state <= RX_IDLE;
          else begin
            state   <= RX_DATA;
            cnt     <= BIT_TC;
            bit_idx <= '0;
          end
        end else cnt <= cnt - CW'(1);
        RX_DATA: if (cnt == '0) begin
          shreg   <= {rx_sync, shreg[7:1]};
          cnt     <= BIT_TC;
          bit_idx <= bit_idx + 3'd1;
          if (bit_idx == 3'd7) state <= RX_STOP;
        end else cnt <= cnt - CW'(1);
        RX_STOP: if (cnt == '0) begin
          if (rx_sync) byte_valid_o <= 1'b1;
          else         frame_err_o  <= 1'b1;
          state <= RX_IDLE;
        end else cnt <= cnt - CW'(1);
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_prog_loader.sv
// Boot loader: assembles little-endian words from UART bytes, writes them to instruction
// memory, and releases the core reset after the terminator word or when memory is full.
//   state   | meaning
//   S_LOAD  | collecting bytes of the next word
//   S_WRITE | word presented on req/gnt port, waiting for grant
//   S_DONE  | load finished, core released
module uart_prog_loader
  import uart_prog_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned MEM_AW       = 12,
  parameter logic [31:0] END_WORD     = DEFAULT_END_WORD
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              uart_rx_i,
  output logic              mem_req_o,
  input  logic              mem_gnt_i,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              core_rst_no,
  output logic              done_o,
  output logic              frame_err_o,
  output logic              overrun_o,
  output logic [MEM_AW:0]   word_cnt_o
);

  localparam logic [MEM_AW-1:0] ADDR_MAX = '1;

  logic [7:0]    rx_byte;
  logic          rx_valid, rx_ferr;
  loader_state_e state;
  logic [1:0]    idx;
  logic [31:0]   word_asm, asm_next;
  logic          skid_full;
  logic [7:0]    skid_byte, load_byte;
  logic          load_take;

  uart_rx_deser #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_deser (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .rx_i         (uart_rx_i),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_valid),
    .frame_err_o  (rx_ferr)
  );

  assign mem_we_o = mem_req_o;
  assign mem_be_o = mem_req_o ? 4'hF : 4'h0;

  // the skid byte is older than any byte arriving now, so it is consumed first
  always_comb begin
    load_byte = skid_full ? skid_byte : rx_byte;
    load_take = skid_full | rx_valid;
    asm_next  = word_asm;
    asm_next[{idx, 3'b000} +: 8] = load_byte;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= S_LOAD;
      idx         <= '0;
      word_asm    <= '0;
      skid_full   <= 1'b0;
      skid_byte   <= '0;
      mem_req_o   <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      word_cnt_o  <= '0;
      done_o      <= 1'b0;
      core_rst_no <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      frame_err_o <= frame_err_o | rx_ferr;
      core_rst_no <= done_o;
      case (state)
        S_LOAD: if (load_take) begin
          word_asm <= asm_next;
          idx      <= idx + 2'd1;
          if (skid_full) begin
            skid_full <= rx_valid;
            skid_byte <= rx_byte;
          end
          if (idx == 2'd3) begin
            if (asm_next == END_WORD) begin
              state  <= S_DONE;
              done_o <= 1'b1;
            end else begin
              mem_wdata_o <= asm_next;
              mem_req_o   <= 1'b1;
              state       <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (rx_valid) begin
            if (skid_full) overrun_o <= 1'b1;
            else begin
              skid_full <= 1'b1;
              skid_byte <= rx_byte;
            end
          end
          if (mem_gnt_i) begin
            mem_req_o  <= 1'b0;
            word_cnt_o <= word_cnt_o + (MEM_AW + 1)'(1);
            if (mem_addr_o == ADDR_MAX) begin
              state  <= S_DONE;
              done_o <= 1'b1;
            end else begin
              mem_addr_o <= mem_addr_o + MEM_AW'(1);
              state      <= S_LOAD;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed and randomized bench for uart_prog_loader against a word-stream reference model.
module tb_uart_prog_loader;

  localparam int CPB = 48;
  localparam logic [31:0] ENDW = 32'h0000_0FFF;

  typedef logic [7:0] byte_q_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n1, rx1, gnt1, req1, we1, core_rst_n1, done1, ferr1, ovr1;
  logic [3:0]  be1;
  logic [11:0] addr1;
  logic [31:0] wdata1;
  logic [12:0] cnt1;
  logic        rst_n2, rx2, gnt2, req2, we2, core_rst_n2, done2, ferr2, ovr2;
  logic [3:0]  be2;
  logic [1:0]  addr2;
  logic [31:0] wdata2;
  logic [2:0]  cnt2;

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .MEM_AW(12), .END_WORD(ENDW)) dut (
    .clk_i(clk), .rst_ni(rst_n1), .uart_rx_i(rx1), .mem_req_o(req1), .mem_gnt_i(gnt1),
    .mem_we_o(we1), .mem_be_o(be1), .mem_addr_o(addr1), .mem_wdata_o(wdata1),
    .core_rst_no(core_rst_n1), .done_o(done1), .frame_err_o(ferr1), .overrun_o(ovr1),
    .word_cnt_o(cnt1)
  );

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .MEM_AW(2), .END_WORD(ENDW)) dut2 (
    .clk_i(clk), .rst_ni(rst_n2), .uart_rx_i(rx2), .mem_req_o(req2), .mem_gnt_i(gnt2),
    .mem_we_o(we2), .mem_be_o(be2), .mem_addr_o(addr2), .mem_wdata_o(wdata2),
    .core_rst_no(core_rst_n2), .done_o(done2), .frame_err_o(ferr2), .overrun_o(ovr2),
    .word_cnt_o(cnt2)
  );

  int checks = 0;
  int errors = 0;
  logic [43:0] got1[$];
  logic [43:0] got2[$];
  logic [43:0] exp_q[$];
  byte_q_t stim;
  logic stop_rand;

  // a transfer is seen at the negedge before the edge that completes it
  always @(negedge clk) begin
    if (rst_n1 && req1 && gnt1) got1.push_back({addr1, wdata1});
    if (rst_n2 && req2 && gnt2) got2.push_back({10'd0, addr2, wdata2});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    do w = $urandom; while (w == ENDW);
    return w;
  endfunction

  function automatic void push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) stim.push_back(w[8*i +: 8]);
  endfunction

  // reference: words in arrival order, stop at terminator or when depth words written
  function automatic void build_exp(input int depth);
    logic [31:0] w;
    int n;
    exp_q.delete();
    n = 0;
    for (int i = 0; i + 3 < stim.size(); i += 4) begin
      w = {stim[i+3], stim[i+2], stim[i+1], stim[i]};
      if (w == ENDW) break;
      exp_q.push_back({12'(n), w});
      n++;
      if (n == depth) break;
    end
  endfunction

  task automatic set_rx(input int which, input logic v);
    if (which == 1) rx1 = v; else rx2 = v;
  endtask

  task automatic send_byte(input int which, input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      set_rx(which, fr[i]);
      repeat (CPB) @(negedge clk);
    end
    set_rx(which, 1'b1);
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_stim(input int which);
    for (int i = 0; i < stim.size(); i++) send_byte(which, stim[i], 1'b1);
  endtask

  task automatic cmp_writes(input string tag, input int which);
    logic [43:0] g[$];
    if (which == 1) g = got1; else g = got2;
    check({tag, "_count"}, 64'(g.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check(tag, (i < g.size()) ? 64'(g[i]) : {64{1'bx}}, 64'(exp_q[i]));
  endtask

  task automatic wait_done1(input string tag);
    int n = 0;
    while (done1 !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(done1), 64'(1));
  endtask

  task automatic do_reset1();
    rst_n1 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", 64'({req1, we1, be1, core_rst_n1, done1, ferr1, ovr1, cnt1}), 64'(0));
    check("rst_data", 64'({addr1, wdata1}), 64'(0));
    got1.delete();
    rst_n1 = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [31:0] w;
    rx1 = 1'b1; rx2 = 1'b1; gnt1 = 1'b1; gnt2 = 1'b1;
    rst_n1 = 1'b0; rst_n2 = 1'b0; stop_rand = 1'b0;
    repeat (2) @(negedge clk);
    rst_n2 = 1'b1;
    do_reset1();

    // two program words then terminator, grant always high
    stim = '{8'h13, 8'h01, 8'h20, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hFF, 8'h0F, 8'h00, 8'h00};
    build_exp(4096);
    check("t1_model_words", 64'(exp_q.size()), 64'(2));
    fork
      send_stim(1);
      begin
        wait_done1("t1_done");
        check("t1_core_rst_lag", 64'(core_rst_n1), 64'(0));
        @(negedge clk);
        check("t1_core_rst", 64'(core_rst_n1), 64'(1));
      end
    join
    cmp_writes("t1_writes", 1);
    check("t1_word_cnt", 64'(cnt1), 64'(2));
    check("t1_no_err", 64'({ferr1, ovr1}), 64'(0));

    // framing error byte is dropped, assembly continues
    do_reset1();
    send_byte(1, 8'hA5, 1'b0);
    stim = '{8'h13, 8'h01, 8'h20, 8'h00, 8'hFF, 8'h0F, 8'h00, 8'h00};
    build_exp(4096);
    send_stim(1);
    wait_done1("t2_done");
    check("t2_frame_err", 64'(ferr1), 64'(1));
    cmp_writes("t2_writes", 1);

    // short glitch on the line produces nothing
    do_reset1();
    rx1 = 1'b0;
    repeat (20) @(negedge clk);
    rx1 = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    stim.delete();
    push_word(rand_word());
    push_word(ENDW);
    build_exp(4096);
    send_stim(1);
    wait_done1("t3_done");
    check("t3_frame_err", 64'(ferr1), 64'(0));
    cmp_writes("t3_writes", 1);

    // grant stalled: one byte skids, the next overruns; port stays stable
    do_reset1();
    gnt1 = 1'b0;
    stim.delete();
    w = rand_word();
    push_word(w);
    send_stim(1);
    begin
      logic [31:0] w2;
      logic [7:0]  junk;
      w2 = rand_word();
      junk = 8'($urandom);
      fork
        begin
          send_byte(1, w2[7:0], 1'b1);
          send_byte(1, junk, 1'b1);
        end
        for (int i = 0; i < 2000; i++) begin
          @(negedge clk);
          check("t4_stable", 64'({req1, we1, be1, addr1, wdata1}), 64'({2'b11, 4'hF, 12'd0, w}));
        end
      join
      check("t4_overrun", 64'(ovr1), 64'(1));
      gnt1 = 1'b1;
      push_word(w2);
      for (int i = 1; i < 4; i++) send_byte(1, w2[8*i +: 8], 1'b1);
      push_word(ENDW);
      for (int i = 0; i < 4; i++) send_byte(1, ENDW[8*i +: 8], 1'b1);
    end
    build_exp(4096);
    wait_done1("t4_done");
    cmp_writes("t4_writes", 1);

    // small memory fills before the terminator
    stim.delete();
    for (int i = 0; i < 5; i++) push_word(rand_word());
    build_exp(4);
    send_stim(2);
    check("t5_done", 64'({done2, core_rst_n2}), 64'(2'b11));
    check("t5_word_cnt", 64'(cnt2), 64'(4));
    cmp_writes("t5_writes", 2);

    // reset mid-word discards the partial bytes
    do_reset1();
    send_byte(1, 8'($urandom), 1'b1);
    send_byte(1, 8'($urandom), 1'b1);
    do_reset1();
    stim.delete();
    push_word(rand_word());
    push_word(ENDW);
    build_exp(4096);
    send_stim(1);
    wait_done1("t6_done");
    cmp_writes("t6_writes", 1);
    check("t6_word_cnt", 64'(cnt1), 64'(1));

    // random words with a randomly toggling grant
    do_reset1();
    stim.delete();
    for (int i = 0; i < 4; i++) push_word(rand_word());
    push_word(ENDW);
    build_exp(4096);
    fork
      begin
        send_stim(1);
        stop_rand = 1'b1;
      end
      while (!stop_rand) begin
        @(negedge clk);
        gnt1 = 1'($urandom_range(0, 1));
      end
    join
    gnt1 = 1'b1;
    wait_done1("t7_done");
    cmp_writes("t7_writes", 1);
    check("t7_flags", 64'({ferr1, ovr1, core_rst_n1}), 64'(3'b001));
    check("t7_word_cnt", 64'(cnt1), 64'(4));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Boot-time program loader. Deserialises 8N1 UART bytes from `uart_rx_i` and assembles little-endian 32-bit words.
- Writes each word into instruction memory through a req/gnt port at incrementing word addresses.
- Holds the core in reset until an end-of-program marker word arrives, or memory fills, then releases it.
- Sits between the SoC UART pin and the instruction RAM, ahead of the core reset.

Parameters:
- CLKS_PER_BIT, 87, clock cycles per UART bit (10 MHz / 115200, rounded up); must be >= 4.
- MEM_AW, 12, instruction memory word-address width (depth 2**MEM_AW words).
- END_WORD, 32'h0000_0FFF, terminator word; it is never written to memory.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- uart_rx_i  in  1  serial input, idle high, asynchronous to clk_i
- mem_req_o  out  1  write request, held until granted
- mem_gnt_i  in  1  memory grant; a transfer completes on any cycle where req && gnt
- mem_we_o  out  1  write enable, equal to mem_req_o
- mem_be_o  out  4  byte enables, 4'hF while req, else 0
- mem_addr_o  out  MEM_AW  word address
- mem_wdata_o  out  32  assembled word
- core_rst_no  out  1  core reset, active-low
- done_o  out  1  load complete, sticky until reset
- frame_err_o  out  1  sticky framing error
- overrun_o  out  1  sticky byte-drop error
- word_cnt_o  out  MEM_AW+1  number of words written

Behaviour:
- Reset values:
  - All outputs 0; core_rst_no=0, so the core is held in reset.
  - Internal state: deserialiser IDLE, loader S_LOAD, byte index 0, address 0, skid buffer empty.
- Deserialiser, with all timing measured from the synchronised signal:
  - `uart_rx_i` passes through a 2-flop synchroniser.
  - In IDLE, a synchronised falling edge starts the counter.
  - At CLKS_PER_BIT/2 the line is re-sampled. If it is high, treat it as a glitch and return to IDLE with no output.
  - Then 8 data bits are sampled LSB-first, each CLKS_PER_BIT apart, followed by the stop bit.
  - Stop=1: pulse byte_valid for 1 cycle, on the cycle after the stop sample.
  - Stop=0: pulse frame_err for 1 cycle and discard the byte.
  - Either way, return to IDLE; no re-arm until the line is high again.
- Loader FSM states: S_LOAD, S_WRITE, S_DONE.
- S_LOAD:
  - On a byte (from the skid buffer first, else byte_valid), write it to word[8*idx +: 8] and increment idx.
  - On the 4th byte, idx wraps to 0, then:
    - If the assembled word == END_WORD, go to S_DONE.
    - Otherwise, register mem_wdata_o and go to S_WRITE. mem_req_o rises the cycle after the 4th byte.
- S_WRITE:
  - mem_req_o, mem_we_o, addr and wdata are held stable until mem_gnt_i.
  - On a gnt cycle: addr+1 and word_cnt+1.
    - If the address just written was 2**MEM_AW-1, go to S_DONE (memory full, no address wrap).
    - Otherwise, return to S_LOAD.
  - mem_req_o drops the cycle after gnt.
- Skid buffer:
  - A byte_valid arriving while in S_WRITE goes into a 1-entry skid buffer.
  - If the skid buffer is already full, set overrun_o and drop the new byte.
- S_DONE:
  - done_o=1 on entry.
  - core_rst_no=1 one cycle after done_o rises (registered).
  - Received bytes are ignored; frame_err_o stays live.
- frame_err_o: set on any framing pulse. The byte index is not advanced, so assembly continues with the next good byte.
- Simultaneous events: a gnt in the same cycle as byte_valid takes the byte into the skid buffer. The buffer drains in S_LOAD the next cycle, with no loss.
- Reset mid-operation, asynchronous: outstanding req drops immediately, partial word is discarded, core_rst_no=0, done/errors clear.

Decomposition:
- Package uart_prog_loader_pkg:
  - loader_state_e enum {S_LOAD, S_WRITE, S_DONE}
  - uart_rx_state_e enum {RX_IDLE, RX_START, RX_DATA, RX_STOP}
  - DEFAULT_END_WORD constant
- Sub-module uart_rx_deser:
  - Parameter: CLKS_PER_BIT.
  - Ports: clk_i, rst_ni, rx_i, byte_o[7:0], byte_valid_o, frame_err_o.
  - Contains the synchroniser and bit counter.

Test Plan:
- Send bytes 13 01 20 00 | 93 00 10 00 | FF 0F 00 00, gnt tied 1 -> writes 32'h00200113@0 and 32'h00100093@1 only. Then done_o=1, core_rst_no=1 one cycle later, word_cnt_o=2.
- Byte 0xA5 with stop bit forced 0, then 13 01 20 00 FF 0F 00 00 -> frame_err_o=1, single write 32'h00200113@0, done_o=1.
- 20-cycle low pulse on rx (less than CLKS_PER_BIT/2), then a valid word -> no framing error and no spurious byte; word written correctly.
- gnt held 0 for 2000 cycles while 2 more bytes arrive -> first byte buffered. Second byte sets overrun_o and is dropped. req, addr and wdata remain stable throughout.
- MEM_AW=2, send 5 non-marker words -> 4 writes @0..3, then done_o=1, core_rst_no=1. The 5th word is not written.
- Assert rst_ni low after 2 bytes of a word, release, send a full word -> writes @0 with only post-reset bytes; outputs at reset values during reset.
